// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch-stage PC sequencer.
// FSM states, redirect selects and RAS sizing helper.
package pc_seq_pkg;

    typedef enum logic {
        S_RUN,
        S_HALT
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_RET,
        SEL_JMP,
        SEL_BR
    } pc_sel_e;

    localparam int RAS_DEPTH_DFLT = 4;

    function automatic int ras_ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular LIFO that overwrites the
// oldest entry when a push arrives while full.
module ras_stack
    import pc_seq_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = RAS_DEPTH_DFLT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int PW = ras_ptr_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] top_idx;
    logic [PW:0]   cnt;

    assign top_idx = ptr - 1'b1;
    assign top     = mem[top_idx];
    assign empty   = (cnt == '0);
    assign full    = (cnt == (PW+1)'(DEPTH));

    // ptr is the next write slot; when full it already sits on the oldest
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + 1'b1;
            if (!full)
                cnt <= cnt + 1'b1;
        end else if (pop && !empty) begin
            ptr <= ptr - 1'b1;
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[ptr] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with prioritised redirects,
// return-address stack and run/halt control.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              STEP      = 1,
    parameter int              RAS_DEPTH = RAS_DEPTH_DFLT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic            call,
    input  logic            ret,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);

    pc_state_e       state;
    pc_state_e       state_nxt;
    pc_sel_e         sel;
    logic            push;
    logic            pop;
    logic            ovf;
    logic            unf;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;

    assign pc_seq = pc + STEP_V;
    assign halted = (state == S_HALT);

    ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_seq),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_RUN: begin
                if (halt_req)
                    state_nxt = S_HALT;
                else if (!stall && ret && ras_empty)
                    state_nxt = S_HALT;
            end
            S_HALT: begin
                if (resume)
                    state_nxt = S_RUN;
            end
        endcase
    end

    // redirect priority: halt_req > stall > ret > call > jump > branch
    always_comb begin
        sel  = SEL_HOLD;
        push = 1'b0;
        pop  = 1'b0;
        ovf  = 1'b0;
        unf  = 1'b0;
        if (state == S_RUN && !halt_req && !stall) begin
            if (ret) begin
                if (ras_empty) begin
                    unf = 1'b1;
                end else begin
                    sel = SEL_RET;
                    pop = 1'b1;
                end
            end else if (call) begin
                sel  = SEL_JMP;
                push = 1'b1;
                ovf  = ras_full;
            end else if (jump) begin
                sel = SEL_JMP;
            end else if (branch_taken) begin
                sel = SEL_BR;
            end else begin
                sel = SEL_SEQ;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= RESET_PC;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            ras_overflow  <= ovf;
            ras_underflow <= unf;
            unique case (sel)
                SEL_HOLD: pc <= pc;
                SEL_SEQ:  pc <= pc_seq;
                SEL_RET:  pc <= ras_top;
                SEL_JMP:  pc <= jump_target;
                SEL_BR:   pc <= branch_target;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer against
// a queue-based behavioural model.
module tb_pc_sequencer;

    localparam int          PC_W  = 16;
    localparam logic [15:0] RST_PC = 16'h0010;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, halt_req, resume;
    logic        branch_taken, jump, call, ret;
    logic [15:0] branch_target, jump_target;
    logic [15:0] pc;
    logic        halted, ras_overflow, ras_underflow;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] m_pc;
    logic        m_halt, m_ovf, m_unf;
    logic [15:0] m_ras[$];

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W      (PC_W),
        .RESET_PC  (RST_PC),
        .STEP      (1),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .halt_req      (halt_req),
        .resume        (resume),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .jump_target   (jump_target),
        .pc            (pc),
        .halted        (halted),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, 32'(pc), 32'(m_pc));
        check({tag, ".halted"}, 32'(halted), 32'(m_halt));
        check({tag, ".ovf"}, 32'(ras_overflow), 32'(m_ovf));
        check({tag, ".unf"}, 32'(ras_underflow), 32'(m_unf));
    endtask

    task automatic idle();
        stall = 0; halt_req = 0; resume = 0;
        branch_taken = 0; jump = 0; call = 0; ret = 0;
        branch_target = '0; jump_target = '0;
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_halt = 0; m_ovf = 0; m_unf = 0;
        m_ras.delete();
    endtask

    // one instruction of the architectural behaviour
    task automatic model_step();
        m_ovf = 0;
        m_unf = 0;
        if (m_halt) begin
            if (resume) m_halt = 0;
        end else if (halt_req) begin
            m_halt = 1;
        end else if (stall) begin
        end else if (ret) begin
            if (m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_unf = 1;
                m_halt = 1;
            end
        end else if (call) begin
            m_ras.push_back(m_pc + 16'd1);
            if (m_ras.size() > DEPTH) begin
                void'(m_ras.pop_front());
                m_ovf = 1;
            end
            m_pc = jump_target;
        end else if (jump) begin
            m_pc = jump_target;
        end else if (branch_taken) begin
            m_pc = branch_target;
        end else begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        idle();
    endtask

    task automatic do_jump(input logic [15:0] t);
        jump = 1; jump_target = t; step("jump");
    endtask

    task automatic do_call(input logic [15:0] t);
        call = 1; jump_target = t; step("call");
    endtask

    initial begin
        idle();
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 0;
        repeat (4) step("freerun");

        do_jump(16'h0020);
        jump = 1; jump_target = 16'h0100;
        branch_taken = 1; branch_target = 16'h0200;
        step("jump_vs_br");
        step("after_jump");

        do_jump(16'h0005);
        do_call(16'h0300);
        step("sub1");
        step("sub2");
        ret = 1; step("ret");
        ret = 1; step("ret_empty");
        step("halt_hold");
        resume = 1; step("resume");

        do_jump(16'h1000);
        for (int i = 0; i < 5; i++)
            do_call(16'h2000 + 16'(i) * 16'h1000);
        for (int i = 0; i < 5; i++) begin
            ret = 1; step("nested_ret");
        end
        resume = 1; step("resume2");

        do_jump(16'h0040);
        for (int i = 0; i < 3; i++) begin
            stall = 1; branch_taken = 1; branch_target = 16'h0500;
            step("stall_br");
        end
        stall = 1; halt_req = 1; step("halt_stall");
        jump = 1; jump_target = 16'h0777; step("halt_ignore");
        resume = 1; step("resume3");
        step("post_resume");

        do_call(16'h0600);
        do_call(16'h0700);
        halt_req = 1; call = 1; jump_target = 16'h0800;
        step("halt_vs_call");
        #3;
        reset = 1;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        reset = 0;
        #1;
        ret = 1; step("ret_after_reset");
        resume = 1; step("resume4");

        do_jump(16'hFFFF);
        step("wrap");

        for (int i = 0; i < 400; i++) begin
            halt_req      = ($urandom_range(0, 19) == 0);
            resume        = ($urandom_range(0, 3) == 0);
            stall         = ($urandom_range(0, 5) == 0);
            ret           = ($urandom_range(0, 4) == 0);
            call          = ($urandom_range(0, 4) == 0);
            jump          = ($urandom_range(0, 5) == 0);
            branch_taken  = ($urandom_range(0, 4) == 0);
            jump_target   = 16'($urandom);
            branch_target = 16'($urandom);
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer. It supersedes the plain enable-gated PC register in the fetch stage.
- Adds branch, jump, call and return redirection with fixed priority.
- Holds return addresses in a small return-address stack (RAS).
- Handles stall, plus halt/resume through a two-state FSM.
- Drives the instruction-memory address and reports halt and RAS error status to the control unit.

Parameters:
PC_W, 16, PC width in bits.
RESET_PC, 0, PC value loaded on reset (PC_W bits).
STEP, 1, sequential increment per instruction.
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
stall  in  1  hold PC this cycle; all redirect inputs ignored.
halt_req  in  1  request entry to HALT (e.g. HALT opcode decoded).
resume  in  1  leave HALT.
branch_taken  in  1  conditional branch resolved taken.
branch_target  in  PC_W  branch destination.
jump  in  1  unconditional jump.
call  in  1  call: jump to jump_target and push return address.
ret  in  1  return: pop RAS into PC.
jump_target  in  PC_W  destination for jump/call.
pc  out  PC_W  current PC (registered).
halted  out  1  1 while FSM is in HALT (registered).
ras_overflow  out  1  one-cycle pulse: push onto full RAS.
ras_underflow  out  1  one-cycle pulse: pop from empty RAS.

Behaviour:
- Reset (async, any time, including mid-halt or mid-stall):
  - pc=RESET_PC, FSM=RUN, halted=0.
  - RAS empty (count=0, pointer=0), both error pulses 0.
- All outputs are registered. Redirects take effect on the edge that samples them: new pc is visible the next cycle.
- FSM states RUN and HALT.
- RUN, decided each edge in this priority order:
  1. halt_req=1 -> pc holds; FSM->HALT; halted=1 next cycle. Beats stall and all redirects.
  2. stall=1 -> pc holds; RAS untouched; redirects dropped, not queued.
  3. ret=1, RAS non-empty -> pc<=top entry; pop.
  4. ret=1, RAS empty -> pc holds; ras_underflow=1 for one cycle; FSM->HALT.
  5. call=1 -> push (pc+STEP) mod 2^PC_W; pc<=jump_target.
  6. jump=1 -> pc<=jump_target.
  7. branch_taken=1 -> pc<=branch_target.
  8. otherwise -> pc<=(pc+STEP) mod 2^PC_W; wraps silently, e.g. 0xFFFF+1 -> 0x0000 at PC_W=16.
- Simultaneous call and ret: ret wins, no push. Lower-priority redirects in the same cycle are ignored.
- RAS overflow: push when count==RAS_DEPTH overwrites the oldest entry (circular buffer). The new entry becomes top, count stays RAS_DEPTH, ras_overflow pulses one cycle. Flow continues.
- HALT:
  - pc frozen; stall, redirects and halt_req ignored; RAS untouched.
  - resume=1 -> FSM->RUN; halted=0 next cycle. pc does not advance on the resume edge; normal sequencing starts the following edge.
- Error pulses are asserted only on the edge that causes them and clear on the next edge.

Decomposition:
- Package pc_seq_pkg holds:
  - FSM state enum {S_RUN, S_HALT}.
  - Redirect-select enum {SEL_HOLD, SEL_SEQ, SEL_RET, SEL_JMP, SEL_BR}.
  - Localparam for RAS pointer width, clog2(RAS_DEPTH).
- One sub-module, ras_stack: a parametrised circular LIFO with push, pop, top, empty and full outputs, overwrite-on-full, and the same async reset.
- The priority select and FSM stay in pc_sequencer.

Test Plan:
- Reset then 4 free-run cycles, RESET_PC=0x0010, STEP=1 -> pc 0x0010, 0x0011, 0x0012, 0x0013, 0x0014; halted=0.
- At pc=0x0020, pulse jump (target 0x0100) together with branch_taken (target 0x0200) -> pc=0x0100 next cycle; then 0x0101.
- At pc=0x0005, call to 0x0300; run 2 cycles; ret -> pc 0x0300, 0x0301, 0x0302, 0x0006. Next ret with empty RAS -> ras_underflow pulse, pc holds 0x0006, halted=1.
- With RAS_DEPTH=4, 5 nested calls from distinct pcs, then 5 rets -> ras_overflow on the 5th call. Rets return the 4 newest addresses in LIFO order; the 5th ret underflows.
- stall held 3 cycles at pc=0x0040 while branch_taken is pulsed -> pc stays 0x0040 and the branch is lost. halt_req together with stall -> halted=1. resume -> pc 0x0040 on the resume edge, 0x0041 on the next edge.
- Assert reset asynchronously mid-HALT with 2 RAS entries -> pc=RESET_PC immediately, halted=0, RAS empty (a following ret underflows). Set pc=0xFFFF at PC_W=16 and run sequentially -> pc=0x0000.
